// File: rtl/xor_descrambler.sv
// rtl/xor_descrambler.sv - LFSR keystream XOR descrambler with ready/valid handshake
//
// Purpose:
//   Descrambles a stream of WIDTH-bit words by XOR with a 16-bit Fibonacci
//   LFSR keystream. The LFSR advances exactly once per accepted word, so the
//   same block with the same seed also acts as the scrambler.
//   Optional macro: XOR_DESCRAMBLER_PARITY_EN adds per-word parity checking.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   seed_load  in   load seed (zero seed replaced by ZERO_SEED_SUB), enter RUN
//   seed       in   16-bit keystream seed
//   in_valid   in   in_data valid
//   in_data    in   scrambled word
//   in_ready   out  word accepted this cycle
//   out_valid  out  out_data valid
//   out_data   out  descrambled word
//   out_ready  in   downstream accepts out_data
//   word_cnt   out  words accepted since last seed load (wraps)
//   running    out  state is RUN
//   in_par     in   even parity of in_data        (XOR_DESCRAMBLER_PARITY_EN only)
//   par_err    out  parity mismatch for out_data  (XOR_DESCRAMBLER_PARITY_EN only)

module xor_descrambler #(
  parameter int          WIDTH         = 16,
  parameter logic [15:0] ZERO_SEED_SUB = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             seed_load,
  input  logic [15:0]      seed,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [15:0]      word_cnt,
  output logic             running
`ifdef XOR_DESCRAMBLER_PARITY_EN
  ,
  input  logic             in_par,
  output logic             par_err
`endif
);

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e           state_q, state_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [15:0]      word_cnt_q, word_cnt_d;
  logic [WIDTH-1:0] keystream;
  logic [15:0]      lfsr_step;
  logic             xfer;

  // Keystream word: LFSR truncated for narrow words, zero-extended for wide ones.
  generate
    if (WIDTH > 16) begin : g_ks_wide
      assign keystream = {{(WIDTH-16){1'b0}}, lfsr_q};
    end else begin : g_ks_narrow
      assign keystream = lfsr_q[WIDTH-1:0];
    end
  endgenerate

  assign lfsr_step = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  // A seed load takes priority over data so a re-seed never consumes a word.
  assign running  = (state_q == S_RUN);
  assign in_ready = running & ~seed_load & (~out_valid_q | out_ready);
  assign xfer     = in_valid & in_ready;

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign word_cnt  = word_cnt_q;

`ifdef XOR_DESCRAMBLER_PARITY_EN
  logic par_err_q, par_err_d;
  assign par_err = par_err_q;
`endif

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    word_cnt_d  = word_cnt_q;
`ifdef XOR_DESCRAMBLER_PARITY_EN
    par_err_d   = par_err_q;
`endif
    if (seed_load) begin
      state_d     = S_RUN;
      lfsr_d      = (seed == 16'h0000) ? ZERO_SEED_SUB : seed;
      out_valid_d = 1'b0;
      word_cnt_d  = 16'h0000;
`ifdef XOR_DESCRAMBLER_PARITY_EN
      par_err_d   = 1'b0;
`endif
    end else if (xfer) begin
      lfsr_d      = lfsr_step;
      out_valid_d = 1'b1;
      out_data_d  = in_data ^ keystream;
      word_cnt_d  = word_cnt_q + 16'h0001;
`ifdef XOR_DESCRAMBLER_PARITY_EN
      par_err_d   = (^in_data) != in_par;
`endif
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
`ifdef XOR_DESCRAMBLER_PARITY_EN
      par_err_d   = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      lfsr_q      <= ZERO_SEED_SUB;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      word_cnt_q  <= 16'h0000;
`ifdef XOR_DESCRAMBLER_PARITY_EN
      par_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      word_cnt_q  <= word_cnt_d;
`ifdef XOR_DESCRAMBLER_PARITY_EN
      par_err_q   <= par_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_xor_descrambler.sv
// tb/tb_xor_descrambler.sv - self-checking bench for xor_descrambler

module tb_xor_descrambler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        seed_load = 1'b0;
  logic [15:0] seed = 16'h0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = 16'h0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready = 1'b1;
  logic [15:0] word_cnt;
  logic        running;
`ifdef XOR_DESCRAMBLER_PARITY_EN
  logic        in_par = 1'b0;
  logic        par_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  xor_descrambler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seed_load (seed_load),
    .seed      (seed),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .word_cnt  (word_cnt),
    .running   (running)
`ifdef XOR_DESCRAMBLER_PARITY_EN
    ,
    .in_par    (in_par),
    .par_err   (par_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Keystream as plain arithmetic: shift left, feedback = taps 15^13^12^10.
  function automatic int lfsr_next(input int l);
    int fb;
    fb = ((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 1;
    return ((l << 1) & 32'hFFFF) | fb;
  endfunction

  function automatic int ks_at(input int s, input int n);
    int l;
    l = (s == 0) ? 32'hACE1 : s;
    for (int k = 0; k < n; k++) l = lfsr_next(l);
    return l;
  endfunction

  // Transaction-level model of what the outputs must be.
  bit m_running = 0;
  int m_lfsr    = 32'hACE1;
  int m_cnt     = 0;
  bit m_ov      = 0;
  int m_od      = 0;
  bit m_pe      = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_running = 0; m_lfsr = 32'hACE1; m_cnt = 0; m_ov = 0; m_od = 0; m_pe = 0;
    end else begin
      bit accept;
      accept = m_running && !seed_load && (!m_ov || out_ready) && in_valid;
      if (seed_load) begin
        m_running = 1;
        m_lfsr    = (seed == 0) ? 32'hACE1 : int'(seed);
        m_cnt     = 0;
        m_ov      = 0;
        m_pe      = 0;
      end else if (accept) begin
        m_od   = int'(in_data) ^ m_lfsr;
        m_ov   = 1;
        m_cnt  = (m_cnt + 1) % 65536;
        m_lfsr = lfsr_next(m_lfsr);
`ifdef XOR_DESCRAMBLER_PARITY_EN
        m_pe   = (^in_data) != in_par;
`endif
      end else if (m_ov && out_ready) begin
        m_ov = 0;
        m_pe = 0;
      end
    end
  end

  logic [15:0] got[$];

  always @(negedge clk) begin
    chk("running",   running,   m_running);
    chk("in_ready",  in_ready,  m_running && !seed_load && (!m_ov || out_ready));
    chk("out_valid", out_valid, m_ov);
    chk("word_cnt",  word_cnt,  m_cnt);
    if (m_ov) chk("out_data", out_data, m_od);
`ifdef XOR_DESCRAMBLER_PARITY_EN
    if (m_ov) chk("par_err", par_err, m_pe);
`endif
    if (out_valid && out_ready) got.push_back(out_data);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] s);
    seed = s; seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
  endtask

  task automatic send(input logic [15:0] d);
    in_valid = 1'b1; in_data = d;
    tick();
    in_valid = 1'b0;
  endtask

  logic [15:0] plain [8];

  initial begin
    repeat (2) tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data",  out_data,  0);
    chk("rst_word_cnt",  word_cnt,  0);
    chk("rst_running",   running,   0);
    chk("rst_in_ready",  in_ready,  0);
    rst_n = 1'b1;
    in_valid = 1'b1;
    tick();
    chk("idle_in_ready", in_ready, 0);
    in_valid = 1'b0;

    // Known-answer vector with seed 1.
    load(16'h0001);
    chk("ka_running", running, 1);
    send(16'h1559);
    chk("ka_word0", out_data, 16'h1558);
    chk("ka_valid0", out_valid, 1);
    send(16'h1551);
    chk("ka_word1", out_data, 16'h1553);
    chk("ka_cnt2", word_cnt, 2);
    send(16'h0000);
    chk("ka_lfsr_after2", out_data, 16'h0004);
    tick();
    chk("ka_valid_drop", out_valid, 0);

    // Zero seed substitution.
    load(16'h0000);
    send(16'h0000);
    chk("zero_seed", out_data, 16'hACE1);
    tick();

    // Backpressure: output held, no LFSR step, no count change.
    load(16'h1234);
    out_ready = 1'b0;
    send(16'h0000);
    chk("bp_first", out_data, 16'h1234);
    in_valid = 1'b1; in_data = 16'hFFFF;
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", in_ready, 0);
      tick();
      chk("bp_hold_data", out_data, 16'h1234);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_cnt", word_cnt, 1);
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("bp_release", out_data, 16'hDB96);
    chk("bp_cnt", word_cnt, 2);

    // Seed load beats a simultaneous input while output pending.
    out_ready = 1'b0;
    tick();
    chk("sl_pending", out_valid, 1);
    seed = 16'h00FF; seed_load = 1'b1; in_valid = 1'b1; in_data = 16'h1111;
    chk("sl_in_ready", in_ready, 0);
    tick();
    seed_load = 1'b0; in_valid = 1'b0;
    chk("sl_valid", out_valid, 0);
    chk("sl_cnt", word_cnt, 0);
    out_ready = 1'b1;

    // Asynchronous reset mid-stream.
    out_ready = 1'b0;
    send(16'hA5A5);
    chk("ar_pending", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_out_valid", out_valid, 0);
    chk("ar_out_data",  out_data,  0);
    chk("ar_word_cnt",  word_cnt,  0);
    chk("ar_running",   running,   0);
    out_ready = 1'b1; in_valid = 1'b1;
    tick();
    rst_n = 1'b1;
    repeat (3) begin
      tick();
      chk("ar_in_ready", in_ready, 0);
      chk("ar_no_out", out_valid, 0);
    end
    in_valid = 1'b0;

    // Round trip: pre-scramble with the bench keystream, expect plaintext back.
    load(16'hBEEF);
    got.delete();
    for (int i = 0; i < 8; i++) begin
      plain[i] = 16'(i * 16'h1111 + 3);
      send(plain[i] ^ 16'(ks_at(16'hBEEF, i)));
    end
    tick();
    chk("rt_count", got.size(), 8);
    for (int i = 0; i < 8 && i < got.size(); i++) chk("rt_word", got[i], plain[i]);

`ifdef XOR_DESCRAMBLER_PARITY_EN
    load(16'h0101);
    in_par = 1'b0;
    send(16'h0001);
    chk("par_err_set", par_err, 1);
    chk("par_valid", out_valid, 1);
    in_par = 1'b1;
    send(16'h0001);
    chk("par_err_clr", par_err, 0);
    in_par = 1'b0;
    tick();
`endif

    // Counter wrap after 65536 accepted words.
    load(16'h5555);
    in_valid = 1'b1; in_data = 16'h5A5A;
    repeat (65535) tick();
    chk("wrap_ffff", word_cnt, 16'hFFFF);
    tick();
    in_valid = 1'b0;
    chk("wrap_zero", word_cnt, 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
